// File: rtl/ped_track.sv
// ped_track: pedestal tracker for one ADC channel.
//
// Averages gated ADC samples over a power-of-two window (length 2^wl,
// wl taken from wlog clamped to 1..PBITS) and updates the pedestal
// estimate at each window close according to the selected mode:
//   0 = full average, 1 = step +/-1 with small-signal gate,
//   2 = hybrid (average while unlocked, step while locked), 3 = freeze.
// A stall timeout drops lock and discards the partial window after
// 2^PBITS consecutive rejected samples in modes 1/2.
//
// Ports:
//   clk        ADC clock
//   reset      asynchronous, active-high
//   data       unsigned ADC sample (ABITS)
//   data_valid sample strobe
//   inhibit    suppresses loading of ped after a window close
//   mode       update mode (see above)
//   wlog       log2 window length, clamped to 1..PBITS
//   range      half-width of the small-signal gate
//   ped        pedestal in use (registered)
//   ped_upd    one-cycle pulse on each load of ped
//   locked     tracker stable
//   sub        signed data - ped (ABITS+1), when PED_SUB_EN is defined
//   sub_valid  qualifies sub
//
// Optional feature macro: PED_SUB_EN enables the pedestal-subtracted
// output; without it sub/sub_valid are tied to 0.

module ped_track #(
  parameter int ABITS = 12,
  parameter int PBITS = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ABITS-1:0] data,
  input  logic             data_valid,
  input  logic             inhibit,
  input  logic [1:0]       mode,
  input  logic [3:0]       wlog,
  input  logic [ABITS-1:0] range,
  output logic [ABITS-1:0] ped,
  output logic             ped_upd,
  output logic             locked,
  output logic [ABITS:0]   sub,
  output logic             sub_valid
);

  localparam int SW = PBITS + ABITS;
  localparam logic [3:0]     PMAX    = 4'(PBITS);
  localparam logic [ABITS:0] MAXV    = {1'b0, {ABITS{1'b1}}};
  localparam logic [ABITS:0] ONE_A   = {{ABITS{1'b0}}, 1'b1};
  localparam logic [PBITS:0] ONE_P   = {{PBITS{1'b0}}, 1'b1};
  localparam logic [PBITS:0] TMO_LIM = {1'b1, {PBITS{1'b0}}};

  logic [ABITS-1:0] ped_s_r;
  logic [SW-1:0]    pedsum_r;
  logic [PBITS:0]   cnt_r;
  logic [3:0]       wl_r;
  logic [PBITS:0]   tmo_r;
  logic             locked_r;
  logic             close_r;
  logic [ABITS-1:0] ped_r;
  logic             ped_upd_r;

  logic [3:0]       wlog_clamp_s;
  logic [ABITS:0]   ped_ext_s;
  logic [ABITS:0]   rng_ext_s;
  logic [ABITS:0]   data_ext_s;
  logic [ABITS:0]   lo_s;
  logic [ABITS:0]   hi_sum_s;
  logic [ABITS:0]   hi_s;
  logic             in_gate_s;
  logic             acc_s;
  logic             take_s;
  logic             reject_s;
  logic [SW-1:0]    sum_next_s;
  logic [SW-1:0]    shifted_s;
  logic             round_bit_s;
  logic [PBITS:0]   cnt_next_s;
  logic [PBITS:0]   win_len_s;
  logic             close_s;
  logic [ABITS:0]   avg_s;
  logic [ABITS:0]   diff_s;
  logic             lock_ok_s;
  logic             use_avg_s;
  logic [ABITS-1:0] ped_s_next_s;
  logic [PBITS:0]   tmo_next_s;
  logic             timeout_s;

  // Clamp the requested window exponent to 1..PBITS.
  always_comb begin
    wlog_clamp_s = wlog;
    if (wlog < 4'd1) begin
      wlog_clamp_s = 4'd1;
    end else if (wlog > PMAX) begin
      wlog_clamp_s = PMAX;
    end else begin
      wlog_clamp_s = wlog;
    end
  end

  // Saturated small-signal gate bounds, evaluated one bit wider so nothing wraps.
  always_comb begin
    ped_ext_s  = {1'b0, ped_s_r};
    rng_ext_s  = {1'b0, range};
    data_ext_s = {1'b0, data};
    hi_sum_s   = ped_ext_s + rng_ext_s;
    if (ped_ext_s >= rng_ext_s) begin
      lo_s = ped_ext_s - rng_ext_s;
    end else begin
      lo_s = {(ABITS+1){1'b0}};
    end
    if (hi_sum_s > MAXV) begin
      hi_s = MAXV;
    end else begin
      hi_s = hi_sum_s;
    end
    in_gate_s = (data_ext_s > lo_s) && (data_ext_s < hi_s);
  end

  // Acceptance decision per mode; mode 2 gates only once locked.
  always_comb begin
    acc_s = 1'b0;
    case (mode)
      2'd0:    acc_s = 1'b1;
      2'd1:    acc_s = in_gate_s;
      2'd2:    acc_s = locked_r ? in_gate_s : 1'b1;
      2'd3:    acc_s = 1'b0;
      default: acc_s = 1'b0;
    endcase
    take_s   = data_valid && acc_s;
    reject_s = data_valid && !acc_s && ((mode == 2'd1) || (mode == 2'd2));
  end

  // Window accumulation, close detection, rounded average and next estimate.
  always_comb begin
    sum_next_s  = pedsum_r + {{PBITS{1'b0}}, data};
    cnt_next_s  = cnt_r + ONE_P;
    win_len_s   = ONE_P << wl_r;
    close_s     = take_s && (cnt_next_s == win_len_s);
    shifted_s   = sum_next_s >> wl_r;
    round_bit_s = sum_next_s[wl_r - 4'd1];
    avg_s       = shifted_s[ABITS:0] + {{ABITS{1'b0}}, round_bit_s};
    if (avg_s >= ped_ext_s) begin
      diff_s = avg_s - ped_ext_s;
    end else begin
      diff_s = ped_ext_s - avg_s;
    end
    lock_ok_s = (diff_s <= ONE_A);
    use_avg_s = (mode == 2'd0) || ((mode == 2'd2) && !locked_r);
    // avg never exceeds full scale, and a step only moves towards avg,
    // so both branches stay within 0..2^ABITS-1.
    if (use_avg_s) begin
      ped_s_next_s = avg_s[ABITS-1:0];
    end else if (avg_s > ped_ext_s) begin
      ped_s_next_s = ped_s_r + {{(ABITS-1){1'b0}}, 1'b1};
    end else if (avg_s < ped_ext_s) begin
      ped_s_next_s = ped_s_r - {{(ABITS-1){1'b0}}, 1'b1};
    end else begin
      ped_s_next_s = ped_s_r;
    end
    tmo_next_s = tmo_r + ONE_P;
    timeout_s  = reject_s && (tmo_next_s == TMO_LIM);
  end

  // Tracker state: accumulator, counters, estimate, lock and timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_s_r  <= {ABITS{1'b0}};
      pedsum_r <= {SW{1'b0}};
      cnt_r    <= {(PBITS+1){1'b0}};
      wl_r     <= 4'd1;
      tmo_r    <= {(PBITS+1){1'b0}};
      locked_r <= 1'b0;
      close_r  <= 1'b0;
    end else begin
      close_r <= close_s;
      // A new window picks up wlog only while no window is in progress.
      if ((cnt_r == {(PBITS+1){1'b0}}) && (mode != 2'd3)) begin
        wl_r <= wlog_clamp_s;
      end
      if (take_s) begin
        tmo_r <= {(PBITS+1){1'b0}};
        if (close_s) begin
          pedsum_r <= {SW{1'b0}};
          cnt_r    <= {(PBITS+1){1'b0}};
          ped_s_r  <= ped_s_next_s;
          locked_r <= lock_ok_s;
        end else begin
          pedsum_r <= sum_next_s;
          cnt_r    <= cnt_next_s;
        end
      end else if (reject_s) begin
        if (timeout_s) begin
          tmo_r    <= {(PBITS+1){1'b0}};
          locked_r <= 1'b0;
          pedsum_r <= {SW{1'b0}};
          cnt_r    <= {(PBITS+1){1'b0}};
        end else begin
          tmo_r <= tmo_next_s;
        end
      end
    end
  end

  // Publish the estimate one cycle after a close unless inhibited.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_r     <= {ABITS{1'b0}};
      ped_upd_r <= 1'b0;
    end else if (close_r && !inhibit) begin
      ped_r     <= ped_s_r;
      ped_upd_r <= 1'b1;
    end else begin
      ped_upd_r <= 1'b0;
    end
  end

  assign ped     = ped_r;
  assign ped_upd = ped_upd_r;
  assign locked  = locked_r;

`ifdef PED_SUB_EN
  logic [ABITS:0] sub_r;
  logic           sub_valid_r;

  // Pedestal-subtracted sample, one cycle behind the input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_r       <= {(ABITS+1){1'b0}};
      sub_valid_r <= 1'b0;
    end else begin
      sub_valid_r <= data_valid;
      if (data_valid) begin
        sub_r <= {1'b0, data} - {1'b0, ped_r};
      end
    end
  end

  assign sub       = sub_r;
  assign sub_valid = sub_valid_r;
`else
  assign sub       = {(ABITS+1){1'b0}};
  assign sub_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ped_track.sv
module tb_ped_track;
  localparam int ABITS = 12;
  localparam int PBITS = 4;

  logic             clk;
  logic             reset;
  logic [ABITS-1:0] data;
  logic             data_valid;
  logic             inhibit;
  logic [1:0]       mode;
  logic [3:0]       wlog;
  logic [ABITS-1:0] range;
  logic [ABITS-1:0] ped;
  logic             ped_upd;
  logic             locked;
  logic [ABITS:0]   sub;
  logic             sub_valid;

  int n_checks = 0;
  int n_fail   = 0;

  ped_track #(.ABITS(ABITS), .PBITS(PBITS)) dut (
    .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
    .inhibit(inhibit), .mode(mode), .wlog(wlog), .range(range),
    .ped(ped), .ped_upd(ped_upd), .locked(locked),
    .sub(sub), .sub_valid(sub_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one valid sample; returns 1 time unit after the capturing edge.
  task automatic send(input logic [ABITS-1:0] d);
    data = d;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; data = '0; data_valid = 1'b0; inhibit = 1'b0;
    mode = 2'd0; wlog = 4'd4; range = '0;
    idle(); idle();
    n_checks++; if (ped !== 12'd0) begin n_fail++; $display("FAIL reset_ped got %0d exp 0", ped); end
    n_checks++; if (ped_upd !== 1'b0) begin n_fail++; $display("FAIL reset_upd got %0b exp 0", ped_upd); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %0b exp 0", locked); end
    n_checks++; if (sub !== 13'd0 || sub_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sub got %h/%0b exp 0/0", sub, sub_valid); end
    reset = 1'b0;
    idle();
  endtask

  task automatic test_const_avg();
    mode = 2'd0; wlog = 4'd4;
    for (int i = 0; i < 15; i++) send(12'd100);
    n_checks++; if (ped_upd !== 1'b0) begin n_fail++; $display("FAIL const_early_upd got %0b exp 0", ped_upd); end
    send(12'd100);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL const_lock1 got %0b exp 0", locked); end
    n_checks++; if (ped_upd !== 1'b0) begin n_fail++; $display("FAIL const_latency got %0b exp 0", ped_upd); end
    idle();
    n_checks++; if (ped_upd !== 1'b1 || ped !== 12'd100) begin n_fail++; $display("FAIL const_load got %0d/%0b exp 100/1", ped, ped_upd); end
    idle();
    n_checks++; if (ped_upd !== 1'b0) begin n_fail++; $display("FAIL const_pulse got %0b exp 0", ped_upd); end
    for (int i = 0; i < 16; i++) send(12'd100);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL const_lock2 got %0b exp 1", locked); end
    idle();
    n_checks++; if (ped_upd !== 1'b1 || ped !== 12'd100) begin n_fail++; $display("FAIL const_load2 got %0d/%0b exp 100/1", ped, ped_upd); end
  endtask

  task automatic test_rounding();
    mode = 2'd0; wlog = 4'd1;
    idle();
    send(12'd100); idle(); idle(); idle(); send(12'd101);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL round_lock got %0b exp 1", locked); end
    idle();
    n_checks++; if (ped !== 12'd101 || ped_upd !== 1'b1) begin n_fail++; $display("FAIL round_gap got %0d/%0b exp 101/1", ped, ped_upd); end
    send(12'd101); send(12'd100); idle();
    n_checks++; if (ped !== 12'd101 || ped_upd !== 1'b1) begin n_fail++; $display("FAIL round_b2b got %0d/%0b exp 101/1", ped, ped_upd); end
    // Pull the estimate back to 100 for the stepping test.
    send(12'd100); send(12'd100); idle();
    n_checks++; if (ped !== 12'd100) begin n_fail++; $display("FAIL round_reset100 got %0d exp 100", ped); end
  endtask

  task automatic test_step_mode();
    logic [ABITS-1:0] old_v;
    logic [ABITS-1:0] new_v;
    logic             lk_v;
    mode = 2'd1; wlog = 4'd2; range = 12'd20;
    idle();
    for (int k = 0; k < 11; k++) begin
      old_v = (k < 10) ? 12'(100 + k) : 12'd110;
      new_v = (old_v < 12'd110) ? old_v + 12'd1 : 12'd110;
      lk_v  = (old_v >= 12'd109);
      for (int i = 0; i < 4; i++) send(12'd110);
      n_checks++; if (locked !== lk_v) begin n_fail++; $display("FAIL step_lock[%0d] got %0b exp %0b", k, locked, lk_v); end
      idle();
      n_checks++; if (ped !== new_v || ped_upd !== 1'b1) begin n_fail++; $display("FAIL step_ped[%0d] got %0d/%0b exp %0d/1", k, ped, ped_upd, new_v); end
    end
  endtask

  task automatic test_gate();
    // Estimate to 100 (unlocked), then gate with range 5: lo=95, hi=105.
    mode = 2'd0; wlog = 4'd1;
    send(12'd100); send(12'd100); idle();
    mode = 2'd1; range = 12'd5;
    send(12'd104); send(12'd105); idle();
    n_checks++; if (ped_upd !== 1'b0) begin n_fail++; $display("FAIL gate_hi_excl got upd %0b exp 0", ped_upd); end
    send(12'd95); idle();
    n_checks++; if (ped_upd !== 1'b0) begin n_fail++; $display("FAIL gate_lo_excl got upd %0b exp 0", ped_upd); end
    send(12'd96);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL gate_lock got %0b exp 1", locked); end
    idle();
    n_checks++; if (ped_upd !== 1'b1 || ped !== 12'd100) begin n_fail++; $display("FAIL gate_inner got %0d/%0b exp 100/1", ped, ped_upd); end
    // Estimate to 2: lo clamps to 0, hi = 7.
    mode = 2'd0;
    send(12'd2); send(12'd2); idle();
    mode = 2'd1;
    send(12'd1); send(12'd4095); idle();
    n_checks++; if (ped_upd !== 1'b0) begin n_fail++; $display("FAIL gate_fullscale got upd %0b exp 0", ped_upd); end
    send(12'd1);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL gate_low_lock got %0b exp 1", locked); end
    idle();
    n_checks++; if (ped_upd !== 1'b1 || ped !== 12'd1) begin n_fail++; $display("FAIL gate_low got %0d/%0b exp 1/1", ped, ped_upd); end
  endtask

  task automatic test_timeout();
    // Locked at estimate 1, mode 2: 3 accepted, then 16 rejects.
    mode = 2'd2; wlog = 4'd4; range = 12'd5;
    for (int i = 0; i < 3; i++) send(12'd2);
    for (int i = 0; i < 15; i++) send(12'd1000);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL tmo_early got %0b exp 1", locked); end
    send(12'd1000);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL tmo_unlock got %0b exp 0", locked); end
    // Partial window was discarded: the full 16 must arrive before a close.
    for (int i = 0; i < 15; i++) send(12'd1000);
    idle();
    n_checks++; if (ped_upd !== 1'b0 || ped !== 12'd1) begin n_fail++; $display("FAIL tmo_discard got %0d/%0b exp 1/0", ped, ped_upd); end
    send(12'd1000); idle();
    n_checks++; if (ped !== 12'd1000 || ped_upd !== 1'b1) begin n_fail++; $display("FAIL tmo_reacq got %0d/%0b exp 1000/1", ped, ped_upd); end
  endtask

  task automatic test_inhibit();
    mode = 2'd0; wlog = 4'd1; inhibit = 1'b1;
    send(12'd500); send(12'd500); idle();
    n_checks++; if (ped !== 12'd1000 || ped_upd !== 1'b0) begin n_fail++; $display("FAIL inh_hold got %0d/%0b exp 1000/0", ped, ped_upd); end
    inhibit = 1'b0;
    idle(); idle();
    n_checks++; if (ped !== 12'd1000 || ped_upd !== 1'b0) begin n_fail++; $display("FAIL inh_noretry got %0d/%0b exp 1000/0", ped, ped_upd); end
    send(12'd500); send(12'd500); idle();
    n_checks++; if (ped !== 12'd500 || ped_upd !== 1'b1) begin n_fail++; $display("FAIL inh_release got %0d/%0b exp 500/1", ped, ped_upd); end
  endtask

  task automatic test_freeze();
    mode = 2'd0; wlog = 4'd2;
    send(12'd200); send(12'd200);
    mode = 2'd3;
    for (int i = 0; i < 5; i++) send(12'd0);
    idle();
    n_checks++; if (ped_upd !== 1'b0 || ped !== 12'd500) begin n_fail++; $display("FAIL freeze_hold got %0d/%0b exp 500/0", ped, ped_upd); end
    mode = 2'd0;
    send(12'd200); send(12'd200); idle();
    n_checks++; if (ped !== 12'd200 || ped_upd !== 1'b1) begin n_fail++; $display("FAIL freeze_partial got %0d/%0b exp 200/1", ped, ped_upd); end
  endtask

  task automatic test_sub();
    send(12'd190);
`ifdef PED_SUB_EN
    n_checks++; if (sub !== 13'h1FF6 || sub_valid !== 1'b1) begin n_fail++; $display("FAIL sub_val got %h/%0b exp 1ff6/1", sub, sub_valid); end
    idle();
    n_checks++; if (sub_valid !== 1'b0) begin n_fail++; $display("FAIL sub_valid_drop got %0b exp 0", sub_valid); end
`else
    n_checks++; if (sub !== 13'd0 || sub_valid !== 1'b0) begin n_fail++; $display("FAIL sub_tied got %h/%0b exp 0/0", sub, sub_valid); end
`endif
  endtask

  task automatic test_reset_midwindow();
    // A window is in progress (one sample of 190); reset drops it.
    reset = 1'b1; #1;
    n_checks++; if (ped !== 12'd0 || locked !== 1'b0 || ped_upd !== 1'b0) begin n_fail++; $display("FAIL midrst_state got %0d/%0b/%0b exp 0/0/0", ped, locked, ped_upd); end
    idle();
    reset = 1'b0;
    mode = 2'd0; wlog = 4'd1;
    idle();
    send(12'd50); send(12'd50);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL midrst_lock got %0b exp 0", locked); end
    idle();
    n_checks++; if (ped !== 12'd50 || ped_upd !== 1'b1) begin n_fail++; $display("FAIL midrst_ped got %0d/%0b exp 50/1", ped, ped_upd); end
  endtask

  initial begin
    test_reset();
    test_const_avg();
    test_rounding();
    test_step_mode();
    test_gate();
    test_timeout();
    test_inhibit();
    test_freeze();
    test_sub();
    test_reset_midwindow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
